// File: rtl/fft_xspec_sink.sv
// fft_xspec_sink
//   Receives lock-stepped AXI-Stream beats from the x and y FFT cores,
//   computes X[k]*conj(Y[k]) per bin at full precision and stores one
//   N-bin frame for a downstream reader.
//
//   Optional build macro: XK_INDEX_CHECK_EN
//     defined   - tuser low AW bits of both channels are checked against the
//                 bin counter on every accepted beat; mismatches set err_index.
//     undefined - tuser is ignored and err_index is tied to 0.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   x_/y_tdata,_tvalid,     FFT output streams ({im,re}, signed DW each)
//   _tlast,_tuser
//   s_tready                shared ready for both streams
//   frame_done              one-cycle pulse on the last buffer write of a frame
//   buf_valid               buffer holds a complete frame
//   buf_release             consumer done with the buffer (honoured in HOLD)
//   rd_en, rd_addr, rd_data registered read port, {im,re} each 2DW+1 signed
//   err_clear               clears the sticky error flags
//   err_*                   sticky framing / sync / index error flags
module fft_xspec_sink #(
  parameter int N  = 256,
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*DW-1:0]         x_tdata,
  input  logic                    x_tvalid,
  input  logic                    x_tlast,
  input  logic [15:0]             x_tuser,
  input  logic [2*DW-1:0]         y_tdata,
  input  logic                    y_tvalid,
  input  logic                    y_tlast,
  input  logic [15:0]             y_tuser,
  output logic                    s_tready,
  output logic                    frame_done,
  output logic                    buf_valid,
  input  logic                    buf_release,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [2*(2*DW+1)-1:0]   rd_data,
  input  logic                    err_clear,
  output logic                    err_tlast_early,
  output logic                    err_tlast_missing,
  output logic                    err_sync,
  output logic                    err_index
);

  typedef enum logic [1:0] {RECV, DRAIN, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic                   rdy_en_q;
  logic                   frame_done_q;

  logic signed [2*DW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic                   v1_q, l1_q;
  logic [AW-1:0]          a1_q;
  logic signed [2*DW:0]   re2_q, im2_q;
  logic                   v2_q, l2_q;
  logic [AW-1:0]          a2_q;

  logic [2*(2*DW+1)-1:0]  mem [N];
  logic [2*(2*DW+1)-1:0]  rd_data_q;

  logic                   e_early_q, e_miss_q, e_sync_q, e_idx_q;

  logic signed [DW-1:0]   xr, xi, yr, yi;
  logic                   accept, tlast_any, at_end, last_beat, early_beat;
  logic                   final_write, idx_bad;
  logic                   unused_tuser;

  assign xr = x_tdata[DW-1:0];
  assign xi = x_tdata[2*DW-1:DW];
  assign yr = y_tdata[DW-1:0];
  assign yi = y_tdata[2*DW-1:DW];

  assign accept      = s_tready & x_tvalid & y_tvalid;
  assign tlast_any   = x_tlast | y_tlast;
  assign at_end      = (cnt_q == AW'(N-1));
  assign last_beat   = accept & at_end;
  assign early_beat  = accept & tlast_any & ~at_end;
  assign final_write = v2_q & l2_q;

  assign unused_tuser = ^{x_tuser, y_tuser};

`ifdef XK_INDEX_CHECK_EN
  assign idx_bad = accept & ((x_tuser[AW-1:0] != cnt_q) | (y_tuser[AW-1:0] != cnt_q));
`else
  assign idx_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RECV;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next-state logic; an early tlast aborts the frame by rewinding the counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) cnt_d = (at_end | tlast_any) ? '0 : cnt_q + 1'b1;
    case (state_q)
      RECV:    if (last_beat)   state_d = DRAIN;
      DRAIN:   if (final_write) state_d = HOLD;
      HOLD:    if (buf_release) state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  // Outputs; ready stays low until the first edge after reset release
  always_comb begin
    s_tready  = rdy_en_q & (state_q == RECV);
    buf_valid = (state_q == HOLD);
  end

  // Two-stage arithmetic pipeline: products, then sums
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_rr_q <= '0; p_ii_q <= '0; p_ir_q <= '0; p_ri_q <= '0;
      v1_q <= 1'b0; l1_q <= 1'b0; a1_q <= '0;
      re2_q <= '0; im2_q <= '0;
      v2_q <= 1'b0; l2_q <= 1'b0; a2_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      p_rr_q <= (2*DW)'(xr) * (2*DW)'(yr);
      p_ii_q <= (2*DW)'(xi) * (2*DW)'(yi);
      p_ir_q <= (2*DW)'(xi) * (2*DW)'(yr);
      p_ri_q <= (2*DW)'(xr) * (2*DW)'(yi);
      v1_q   <= accept;
      l1_q   <= last_beat;
      a1_q   <= cnt_q;
      re2_q  <= (2*DW+1)'(p_rr_q) + (2*DW+1)'(p_ii_q);
      im2_q  <= (2*DW+1)'(p_ir_q) - (2*DW+1)'(p_ri_q);
      v2_q   <= v1_q;
      l2_q   <= l1_q;
      a2_q   <= a1_q;
      frame_done_q <= final_write & (state_q == DRAIN);
    end
  end

  // Frame buffer; contents survive reset
  always_ff @(posedge clk) begin
    if (v2_q) mem[a2_q] <= {im2_q, re2_q};
  end

  // Same-cycle read of a location being written returns the old contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  // Sticky errors: a new error in the clearing cycle takes precedence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_early_q <= 1'b0;
      e_miss_q  <= 1'b0;
      e_sync_q  <= 1'b0;
      e_idx_q   <= 1'b0;
    end else begin
      e_early_q <= (e_early_q & ~err_clear) | early_beat;
      e_miss_q  <= (e_miss_q  & ~err_clear) | (last_beat & ~tlast_any);
      e_sync_q  <= (e_sync_q  & ~err_clear) |
                   ((state_q == RECV) & ((x_tvalid != y_tvalid) | (accept & (x_tlast != y_tlast))));
      e_idx_q   <= (e_idx_q   & ~err_clear) | idx_bad;
    end
  end

  assign frame_done        = frame_done_q;
  assign rd_data           = rd_data_q;
  assign err_tlast_early   = e_early_q;
  assign err_tlast_missing = e_miss_q;
  assign err_sync          = e_sync_q;
  assign err_index         = e_idx_q;

endmodule

// File: tb/tb_fft_xspec_sink.sv
module tb_fft_xspec_sink;

  localparam int N  = 256;
  localparam int DW = 16;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2*DW-1:0]   x_tdata = '0, y_tdata = '0;
  logic              x_tvalid = 1'b0, y_tvalid = 1'b0;
  logic              x_tlast = 1'b0, y_tlast = 1'b0;
  logic [15:0]       x_tuser = '0, y_tuser = '0;
  logic              s_tready, frame_done, buf_valid;
  logic              buf_release = 1'b0;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [2*(2*DW+1)-1:0] rd_data;
  logic              err_clear = 1'b0;
  logic              err_tlast_early, err_tlast_missing, err_sync, err_index;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;

  fft_xspec_sink #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tlast(x_tlast), .x_tuser(x_tuser),
    .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tlast(y_tlast), .y_tuser(y_tuser),
    .s_tready(s_tready), .frame_done(frame_done), .buf_valid(buf_valid),
    .buf_release(buf_release), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .err_clear(err_clear), .err_tlast_early(err_tlast_early),
    .err_tlast_missing(err_tlast_missing), .err_sync(err_sync), .err_index(err_index)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: x=(k,0) y=(1,0); mode 1: special complex bins 0/1 else mode 0
  task automatic set_beat(input int k, input int mode);
    int xr, xi, yr, yi;
    xr = k; xi = 0; yr = 1; yi = 0;
    if (mode == 1 && k == 0) begin xr = 3; xi = 4; yr = 1; yi = 2; end
    if (mode == 1 && k == 1) begin xr = -32768; xi = -32768; yr = -32768; yi = 32767; end
    x_tdata = {16'(xi), 16'(xr)};
    y_tdata = {16'(yi), 16'(yr)};
  endtask

  // Drives n beats back to back; returns just after the posedge of the last one
  task automatic send_frame(input int n, input int tlast_at, input int mode, input int bad_idx);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      set_beat(k, mode);
      x_tvalid = 1'b1; y_tvalid = 1'b1;
      x_tlast = (k == tlast_at); y_tlast = (k == tlast_at);
      x_tuser = (k == bad_idx) ? 16'd7 : 16'(k);
      y_tuser = 16'(k);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    x_tvalid = 1'b0; y_tvalid = 1'b0; x_tlast = 1'b0; y_tlast = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c0;
    c0 = fd_cnt;
    for (int i = 0; i < 10 && fd_cnt == c0; i++) @(negedge clk);
    check_eq(tag, fd_cnt - c0, 1);
  endtask

  task automatic read_bin(input int a, output longint re, output longint im);
    logic signed [2*DW:0] re_s, im_s;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = AW'(a);
    @(negedge clk);
    rd_en = 1'b0;
    re_s = rd_data[2*DW:0];
    im_s = rd_data[2*(2*DW+1)-1:2*DW+1];
    re = re_s; im = im_s;
  endtask

  task automatic release_buf(input string tag);
    @(negedge clk);
    buf_release = 1'b1;
    @(negedge clk);
    buf_release = 1'b0;
    check_eq({tag, "_rdy"}, s_tready, 1);
    check_eq({tag, "_bv"}, buf_valid, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    longint re, im;
    int c0;

    // Power-on reset
    repeat (2) @(negedge clk);
    check_eq("rst_rdy", s_tready, 0);
    check_eq("rst_bv", buf_valid, 0);
    check_eq("rst_rd", rd_data, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("por_rdy", s_tready, 1);

    // Reset mid-frame after 40 beats
    send_frame(40, -1, 0, -1);
    @(negedge clk);
    x_tvalid = 1'b0; y_tvalid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("mrst_rdy", s_tready, 0);
    check_eq("mrst_fd", frame_done, 0);
    check_eq("mrst_err", {err_tlast_early, err_tlast_missing, err_sync, err_index}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mrst_rdy1", s_tready, 1);
    repeat (4) @(negedge clk);
    check_eq("mrst_nofd", fd_cnt, 0);

    // Full real frame, frame_done exactly two edges after the last beat
    send_frame(N, N-1, 0, -1);
    idle();
    check_eq("fd_t0", frame_done, 0);
    @(negedge clk);
    check_eq("fd_t1", frame_done, 0);
    @(negedge clk);
    check_eq("fd_t2", frame_done, 1);
    check_eq("fd_bv", buf_valid, 1);
    @(negedge clk);
    check_eq("fd_once", fd_cnt, 1);
    read_bin(5, re, im);
    check_eq("b5_re", re, 5);
    check_eq("b5_im", im, 0);
    read_bin(255, re, im);
    check_eq("b255_re", re, 255);
    check_eq("b255_im", im, 0);
    check_eq("f1_err", {err_tlast_early, err_tlast_missing, err_sync, err_index}, 0);

    // HOLD ignores traffic
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      x_tdata = 32'h1234_5678; y_tdata = 32'h0007_0009;
      x_tvalid = 1'b1; y_tvalid = 1'b1;
      @(negedge clk);
      if (i % 5 == 0) check_eq("hold_rdy", s_tready, 0);
    end
    idle();
    read_bin(5, re, im);
    check_eq("hold_b5", re, 5);
    check_eq("hold_fd", fd_cnt, 1);
    release_buf("rel1");

    // Complex bins and extreme operands
    send_frame(N, N-1, 1, -1);
    idle();
    wait_done("cx_done");
    read_bin(0, re, im);
    check_eq("b0_re", re, 11);
    check_eq("b0_im", im, -2);
    read_bin(1, re, im);
    check_eq("b1_re", re, 32768);
    check_eq("b1_im", im, 64'sd2147450880);
    release_buf("rel2");

    // Early tlast aborts the frame
    c0 = fd_cnt;
    send_frame(100, 99, 0, -1);
    idle();
    check_eq("early_err", err_tlast_early, 1);
    repeat (6) @(negedge clk);
    check_eq("early_nofd", fd_cnt - c0, 0);
    check_eq("early_rdy", s_tready, 1);
    send_frame(N, N-1, 0, -1);
    idle();
    wait_done("after_early");
    check_eq("after_miss", err_tlast_missing, 0);
    release_buf("rel3");
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check_eq("clr_early", err_tlast_early, 0);

    // One-sided valid: nothing accepted, counter untouched
    @(negedge clk);
    x_tvalid = 1'b1; y_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    x_tvalid = 1'b0;
    check_eq("sync_err", err_sync, 1);
    send_frame(N, N-1, 0, 6);
    idle();
    wait_done("sync_done");
    check_eq("sync_miss", err_tlast_missing, 0);
    check_eq("sync_early", err_tlast_early, 0);
`ifdef XK_INDEX_CHECK_EN
    check_eq("idx_err", err_index, 1);
`else
    check_eq("idx_err", err_index, 0);
`endif
    read_bin(6, re, im);
    check_eq("b6_re", re, 6);
    release_buf("rel4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
